// File: rtl/lfsr_test_pkg.sv
// lfsr_test_pkg: shared FSM states, LFSR defaults and the address-seeded pattern function
package lfsr_test_pkg;
  localparam int LFSR_W = 512;
  localparam logic [LFSR_W-1:0] POLY_DEFAULT = {1'b1, 499'd0, 12'h425};
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = {16{32'hA5A5_5A5A}};
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  // Output bit i is the feedback bit produced by step i, so every pattern bit depends on the taps.
  function automatic logic [LFSR_W-1:0] lfsr_pattern(input logic [LFSR_W-1:0] poly, seed, addr);
    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] out;
    s = seed ^ addr;
    out = '0;
    for (int i = 0; i < LFSR_W; i++) begin
      out[i] = ^(s & poly);
      s = {out[i], s[LFSR_W-1:1]};
    end
    return out;
  endfunction
endpackage

// File: rtl/lfsr_pattern_gen.sv
// lfsr_pattern_gen: combinational expected word for an address, shared by generator and checker
module lfsr_pattern_gen
  import lfsr_test_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 33,
  parameter logic [LFSR_W-1:0] POLY = POLY_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] pattern
);
  logic [LFSR_W-1:0] full;
  assign full = lfsr_pattern(POLY, SEED, LFSR_W'(addr));
  assign pattern = full[DATA_WIDTH-1:0];
endmodule

// File: rtl/lfsr_data_checker.sv
// lfsr_data_checker: compares read-back beats against the address-seeded LFSR pattern
module lfsr_data_checker
  import lfsr_test_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 33,
  parameter logic [LFSR_W-1:0] POLY = POLY_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  logic [1:0] state;
  logic v1, v2, v3, m3, acc, clr;
  logic [ADDR_WIDTH-1:0] a1, a2, a3;
  logic [DATA_WIDTH-1:0] d1, d2, e2, pat;
  assign in_ready = state == ST_RUN;
  assign busy = state == ST_RUN || state == ST_DRAIN;
  assign done = state == ST_DONE;
  assign pass = done && err_count == '0 && word_count != '0;
  assign acc = in_valid && in_ready;
  assign clr = start && (state == ST_IDLE || state == ST_DONE);
  lfsr_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .POLY(POLY),
    .SEED(SEED)
  ) u_gen (
    .addr(a1),
    .pattern(pat)
  );
  // Run control: DRAIN waits for the last beat to leave every pipeline stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else if (clr) state <= ST_RUN;
    else if (state == ST_RUN && acc && in_last) state <= ST_DRAIN;
    else if (state == ST_DRAIN && !(v1 || v2 || v3)) state <= ST_DONE;
  end
  // Stage valids; a fresh start flushes anything still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {v1, v2, v3} <= '0;
    else {v1, v2, v3} <= {acc, v1 && !clr, v2 && !clr};
  end
  // Stage payloads: capture, regenerate expected word, reduce to a mismatch flag
  always_ff @(posedge clk) begin
    if (acc) {a1, d1} <= {in_addr, in_data};
    if (v1) {a2, d2, e2} <= {a1, d1, pat};
    if (v2) {a3, m3} <= {a2, |(e2 ^ d2)};
  end
  // Saturating counters and first-error capture, fed from the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      err_count <= '0;
      first_err_valid <= 1'b0;
      first_err_addr <= '0;
    end else if (clr) begin
      word_count <= '0;
      err_count <= '0;
      first_err_valid <= 1'b0;
      first_err_addr <= '0;
    end else if (v3) begin
      word_count <= &word_count ? word_count : word_count + CNT_WIDTH'(1);
      if (m3) err_count <= &err_count ? err_count : err_count + CNT_WIDTH'(1);
      if (m3 && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr <= a3;
      end
    end
  end
endmodule
